// File: rtl/ttt_turn_sequencer_if.sv
// ttt_turn_sequencer_if
//   Bus between the turn sequencer and the tttg game core.
//   board  : {pos1..pos9}, 2 bits per cell (00 empty, 01 player, 10 pc, 11 occupied)
//   who    : winner reported by the core (00 none, 01 player, 10 pc)
//   play   : player-move strobe to the core
//   pc     : computer-move strobe to the core
//   button : one-hot cell select, valid while play is high
//   master : sequencer side; slave : game core side.
interface ttt_turn_sequencer_if;
    logic [17:0] board;
    logic [1:0]  who;
    logic        play;
    logic        pc;
    logic [8:0]  button;

    modport master (
        input  board, who,
        output play, pc, button
    );

    modport slave (
        output board, who,
        input  play, pc, button
    );
endinterface

// File: rtl/ttt_turn_sequencer.sv
// ttt_turn_sequencer
//   Turn scheduler between the raw player buttons and the tttg game core.
//   It accepts one clean player press at a time and turns it into a timed
//   play strobe. After a settle delay it checks the board and then issues a
//   timed pc strobe. The board is checked again after each strobe, and the
//   game ends on a winner or a full board.
//   Multi-button presses and presses on occupied cells produce an illegal pulse.
// Ports
//   clk         : system clock, rising edge
//   reset       : synchronous, active-low
//   start       : level, begins a new game from IDLE / leaves DONE
//   btn_raw     : debounced buttons, bit8 = cell1 ... bit0 = cell9
//   core        : game-core bus (board, who in; play, pc, button out)
//   player_turn : high while a player move is awaited
//   illegal     : one-cycle pulse for a rejected press
//   game_over   : high while the game is finished
//   move_count  : moves accepted this game (both sides), saturates at 9
// Configuration
//   TURN_TIMEOUT_EN : when defined, an idle player is given an automatic move
//                     into the lowest-numbered empty cell after TIMEOUT_CYCLES.
module ttt_turn_sequencer #(
    parameter int unsigned STROBE_CYCLES  = 4,     // 1..15
    parameter int unsigned SETTLE_CYCLES  = 8,     // 1..255
    parameter int unsigned TIMEOUT_CYCLES = 1000   // 1..2^20-1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [8:0]                  btn_raw,
    ttt_turn_sequencer_if.master        core,
    output logic                        player_turn,
    output logic                        illegal,
    output logic                        game_over,
    output logic [3:0]                  move_count
);

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT_P, S_P_STB, S_P_SET, S_CHK_P,
        S_C_STB, S_C_SET, S_CHK_C, S_DONE
    } state_t;

    localparam logic [7:0] STROBE_LOAD = 8'(STROBE_CYCLES - 1);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [8:0]  button_q, button_d;
    logic [3:0]  move_count_q, move_count_d;
    logic        illegal_q, illegal_d;
    logic [8:0]  btn_prev_q, btn_prev_d;

    logic [8:0]  press;
    logic [8:0]  occ;
    logic        press_onehot;
    logic        target_occ;
    logic        game_end;
    logic        accept;
    logic [8:0]  accept_sel;

`ifdef TURN_TIMEOUT_EN
    localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);
    logic [19:0] idle_q, idle_d;
    logic [8:0]  auto_sel;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v >= 4'd9) ? 4'd9 : v + 4'd1;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            button_q     <= '0;
            move_count_q <= '0;
            illegal_q    <= 1'b0;
            btn_prev_q   <= '0;
`ifdef TURN_TIMEOUT_EN
            idle_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            button_q     <= button_d;
            move_count_q <= move_count_d;
            illegal_q    <= illegal_d;
            btn_prev_q   <= btn_prev_d;
`ifdef TURN_TIMEOUT_EN
            idle_q       <= idle_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        for (int unsigned i = 0; i < 9; i++) begin
            occ[i] = |core.board[2*i +: 2];
        end
        press        = btn_raw & ~btn_prev_q;
        press_onehot = (press != '0) && ((press & (press - 9'd1)) == '0);
        target_occ   = |(press & occ);
        game_end     = (core.who != 2'b00) || (&occ);

        state_d      = state_q;
        cnt_d        = cnt_q;
        button_d     = button_q;
        move_count_d = move_count_q;
        illegal_d    = 1'b0;
        btn_prev_d   = btn_raw;
        accept       = 1'b0;
        accept_sel   = '0;
`ifdef TURN_TIMEOUT_EN
        idle_d       = '0;
        // Ascending scan: the last empty cell found is the highest bit,
        // which is the lowest-numbered cell.
        auto_sel     = '0;
        for (int unsigned i = 0; i < 9; i++) begin
            if (!occ[i]) begin
                auto_sel    = '0;
                auto_sel[i] = 1'b1;
            end
        end
`endif

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_WAIT_P;
                    move_count_d = '0;
                end
            end
            S_WAIT_P: begin
                if (press != '0) begin
                    if (!press_onehot || target_occ) begin
                        illegal_d = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        accept_sel = press;
                    end
                end
`ifdef TURN_TIMEOUT_EN
                else if (idle_q == TIMEOUT_LAST) begin
                    if (auto_sel != '0) begin
                        accept     = 1'b1;
                        accept_sel = auto_sel;
                    end else begin
                        idle_d = idle_q;
                    end
                end else begin
                    idle_d = idle_q + 20'd1;
                end
`endif
                if (accept) begin
                    state_d      = S_P_STB;
                    cnt_d        = STROBE_LOAD;
                    button_d     = accept_sel;
                    move_count_d = sat_inc(move_count_q);
                end
            end
            S_P_STB: begin
                if (cnt_q == '0) begin
                    state_d = S_P_SET;
                    cnt_d   = SETTLE_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_P_SET: begin
                if (cnt_q == '0) state_d = S_CHK_P;
                else             cnt_d   = cnt_q - 8'd1;
            end
            S_CHK_P: begin
                if (game_end) begin
                    state_d = S_DONE;
                end else begin
                    state_d      = S_C_STB;
                    cnt_d        = STROBE_LOAD;
                    move_count_d = sat_inc(move_count_q);
                end
            end
            S_C_STB: begin
                if (cnt_q == '0) begin
                    state_d = S_C_SET;
                    cnt_d   = SETTLE_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_C_SET: begin
                if (cnt_q == '0) state_d = S_CHK_C;
                else             cnt_d   = cnt_q - 8'd1;
            end
            S_CHK_C: begin
                state_d = game_end ? S_DONE : S_WAIT_P;
            end
            S_DONE: begin
                if (start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the registered state, so a reset edge drops the
    // strobes immediately.
    always_comb begin
        core.play   = (state_q == S_P_STB);
        core.pc     = (state_q == S_C_STB);
        core.button = (state_q == S_P_STB) ? button_q : '0;
        player_turn = (state_q == S_WAIT_P);
        game_over   = (state_q == S_DONE);
        illegal     = illegal_q;
        move_count  = move_count_q;
    end

endmodule

// File: tb/tb_ttt_turn_sequencer.sv
// tb_ttt_turn_sequencer
//   Randomised bench for ttt_turn_sequencer. A timeline model predicts every
//   output each cycle: an accepted move expands into a queue of per-cycle
//   expected outputs (strobe, settle, check), and the bench plays the game
//   core itself by writing marks into the board when strobes end.
module tb_ttt_turn_sequencer;

    localparam int STB = 4;
    localparam int SET = 8;
`ifdef TURN_TIMEOUT_EN
    localparam int TO  = 50;
`else
    localparam int TO  = 1000;
`endif

    logic       clk;
    logic       reset;
    logic       start;
    logic [8:0] btn_raw;
    logic       player_turn, illegal, game_over;
    logic [3:0] move_count;

    ttt_turn_sequencer_if bus ();

    ttt_turn_sequencer #(
        .STROBE_CYCLES (STB),
        .SETTLE_CYCLES (SET),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .btn_raw    (btn_raw),
        .core       (bus),
        .player_turn(player_turn),
        .illegal    (illegal),
        .game_over  (game_over),
        .move_count (move_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum int {M_IDLE, M_WAIT, M_BUSY, M_DONE} mode_t;
    localparam int A_NONE = 0, A_MARKP = 1, A_MARKC = 2, A_CHKP = 3, A_CHKC = 4;

    typedef struct {
        bit         play;
        bit         pc;
        logic [8:0] btn;
        int         act;
    } slot_t;

    slot_t       sched[$];
    mode_t       m_mode    = M_IDLE;
    int          m_count   = 0;
    bit          m_illegal = 0;
    logic [8:0]  m_prev    = '0;
    logic [8:0]  m_cell    = '0;
    int          m_idle    = 0;
    logic [17:0] board_next = '0;
    bit          preload_en = 0;

    function automatic logic [1:0] cell_val(input logic [17:0] b, input int c);
        logic [17:0] t;
        t = b >> (2 * (9 - c));
        return t[1:0];
    endfunction

    function automatic logic [1:0] winner(input logic [17:0] b);
        int ln [8][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7},
                          '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};
        for (int k = 0; k < 8; k++) begin
            logic [1:0] a;
            a = cell_val(b, ln[k][0]);
            if ((a == 2'b01 || a == 2'b10) && cell_val(b, ln[k][1]) == a && cell_val(b, ln[k][2]) == a)
                return a;
        end
        return 2'b00;
    endfunction

    function automatic int n_empty(input logic [17:0] b);
        int n = 0;
        for (int c = 1; c <= 9; c++) if (cell_val(b, c) == 2'b00) n++;
        return n;
    endfunction

    function automatic bit ended(input logic [17:0] b);
        return (winner(b) != 2'b00) || (n_empty(b) == 0);
    endfunction

    function automatic logic [17:0] set_cell(input logic [17:0] b, input int c, input logic [1:0] v);
        logic [17:0] r;
        r = b;
        r[2*(9-c) +: 2] = v;
        return r;
    endfunction

    // cell number (1..9) of a one-hot button vector
    function automatic int cell_of(input logic [8:0] v);
        for (int c = 1; c <= 9; c++) if (v[9-c]) return c;
        return 0;
    endfunction

    task automatic push_turn(input bit is_pc, input logic [8:0] sel);
        slot_t s;
        for (int i = 0; i < STB; i++) begin
            s.play = !is_pc;
            s.pc   = is_pc;
            s.btn  = is_pc ? 9'd0 : sel;
            s.act  = (i == STB - 1) ? (is_pc ? A_MARKC : A_MARKP) : A_NONE;
            sched.push_back(s);
        end
        for (int i = 0; i < SET; i++) begin
            s.play = 0; s.pc = 0; s.btn = '0; s.act = A_NONE;
            sched.push_back(s);
        end
        s.play = 0; s.pc = 0; s.btn = '0; s.act = is_pc ? A_CHKC : A_CHKP;
        sched.push_back(s);
    endtask

    task automatic accept_move(input logic [8:0] sel);
        m_count = (m_count >= 9) ? 9 : m_count + 1;
        m_cell  = sel;
        m_mode  = M_BUSY;
        m_idle  = 0;
        push_turn(1'b0, sel);
    endtask

    // Advance the model across one rising edge using the inputs now driven.
    task automatic model_edge();
        logic [8:0] press;
        logic [8:0] occ;
        slot_t      s;
        int         empt[$];
        press     = btn_raw & ~m_prev;
        m_prev    = btn_raw;
        m_illegal = 0;
        if (!reset) begin
            m_mode  = M_IDLE;
            m_count = 0;
            m_prev  = '0;
            m_idle  = 0;
            sched.delete();
            return;
        end
        for (int c = 1; c <= 9; c++) occ[9-c] = (cell_val(bus.board, c) != 2'b00);
        case (m_mode)
            M_IDLE: if (start) begin
                m_mode  = M_WAIT;
                m_count = 0;
                m_idle  = 0;
                board_next = '0;
                if (preload_en)
                    for (int c = 1; c <= 9; c++)
                        if ($urandom_range(0, 4) == 0)
                            board_next = set_cell(board_next, c, 2'($urandom_range(1, 3)));
            end
            M_WAIT: begin
                if (press != '0) begin
                    m_idle = 0;
                    if ($countones(press) != 1 || (press & occ) != '0) m_illegal = 1;
                    else accept_move(press);
                end
`ifdef TURN_TIMEOUT_EN
                else if (m_idle + 1 == TO) begin
                    for (int c = 9; c >= 1; c--) if (!occ[9-c]) m_cell = 9'd1 << (9 - c);
                    if (occ != '1) accept_move(m_cell);
                end else begin
                    m_idle++;
                end
`endif
            end
            M_BUSY: begin
                s = sched.pop_front();
                case (s.act)
                    A_MARKP: board_next = set_cell(board_next, cell_of(m_cell), 2'b01);
                    A_MARKC: begin
                        for (int c = 1; c <= 9; c++)
                            if (cell_val(board_next, c) == 2'b00) empt.push_back(c);
                        if (empt.size() > 0)
                            board_next = set_cell(board_next, empt[$urandom_range(0, empt.size() - 1)], 2'b10);
                    end
                    A_CHKP: begin
                        if (ended(bus.board)) m_mode = M_DONE;
                        else begin
                            m_count = (m_count >= 9) ? 9 : m_count + 1;
                            push_turn(1'b1, '0);
                        end
                    end
                    A_CHKC: begin
                        m_mode = ended(bus.board) ? M_DONE : M_WAIT;
                        m_idle = 0;
                    end
                    default: ;
                endcase
            end
            M_DONE: if (start) m_mode = M_IDLE;
            default: ;
        endcase
    endtask

    // One cycle: compare outputs, drive next inputs, advance the model.
    task automatic step(input logic rst_n, input logic st, input logic [8:0] b);
        bit busy;
        @(negedge clk);
        busy = (m_mode == M_BUSY) && (sched.size() > 0);
        check_eq("play",        bus.play,    busy ? sched[0].play : 1'b0);
        check_eq("pc",          bus.pc,      busy ? sched[0].pc   : 1'b0);
        check_eq("button",      bus.button,  busy ? sched[0].btn  : 9'd0);
        check_eq("player_turn", player_turn, m_mode == M_WAIT);
        check_eq("game_over",   game_over,   m_mode == M_DONE);
        check_eq("illegal",     illegal,     m_illegal);
        check_eq("move_count",  move_count,  m_count);
        bus.board = board_next;
        bus.who   = winner(board_next);
        reset     = rst_n;
        start     = st;
        btn_raw   = b;
        model_edge();
    endtask

    initial begin
        logic [8:0] b;
        logic       rs;
        int         r;
        reset     = 1'b0;
        start     = 1'b0;
        btn_raw   = '0;
        bus.board = '0;
        bus.who   = 2'b00;

        // reset, first game, reset in the middle of the play strobe
        repeat (3) step(1'b0, 1'b0, 9'd0);
        step(1'b1, 1'b1, 9'd0);
        step(1'b1, 1'b0, 9'b100000000);
        repeat (2) step(1'b1, 1'b0, 9'b100000000);
        repeat (3) step(1'b0, 1'b0, 9'b100000000);
        step(1'b1, 1'b0, 9'd0);

        // full player + pc turn, then rejected presses
        step(1'b1, 1'b1, 9'd0);
        step(1'b1, 1'b0, 9'd0);
        step(1'b1, 1'b0, 9'b100000000);
        repeat (30) step(1'b1, 1'b0, 9'd0);
        step(1'b1, 1'b0, 9'b010000100);
        repeat (2) step(1'b1, 1'b0, 9'd0);
        repeat (3) step(1'b1, 1'b0, 9'b111111111);
        repeat (TO + 40 < 120 ? TO + 40 : 120) step(1'b1, 1'b0, 9'd0);

        // randomised games with preloaded boards
        preload_en = 1;
        b = '0;
        for (int n = 0; n < 8000; n++) begin
            r  = $urandom_range(0, 99);
            rs = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
            if (r < 30)      b = b;
            else if (r < 60) b = '0;
            else if (r < 85) b = 9'd1 << $urandom_range(0, 8);
            else             b = 9'($urandom_range(0, 511));
            step(rs, ($urandom_range(0, 7) == 0), b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
